// File: rtl/shift_norm_ctrl.sv
// Sequencer for the approximate-multiplier datapath: loads operands A/B, leading-one
// normalizes both, triggers the result load, then de-normalizes R by ka+kb shifts.
module shift_norm_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             msb_a,
    input  logic             msb_b,
    output logic             ld_a,
    output logic             shen_a,
    output logic             ld_b,
    output logic             shen_b,
    output logic             ld_res,
    output logic             shen_res,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        NORM,
        MUL,
        DENORM,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W:0]   rem, rem_nxt;
    logic [CNT_W-1:0] cnt_a_nxt, cnt_b_nxt;
    logic             zero_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
            zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            cnt_a <= cnt_a_nxt;
            cnt_b <= cnt_b_nxt;
            zero  <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        cnt_a_nxt = cnt_a;
        cnt_b_nxt = cnt_b;
        zero_nxt  = zero;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        shen_a    = 1'b0;
        shen_b    = 1'b0;
        ld_res    = 1'b0;
        shen_res  = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    cnt_a_nxt = '0;
                    cnt_b_nxt = '0;
                    zero_nxt  = 1'b0;
                end
            end
            LOAD: begin
                ld_a      = 1'b1;
                ld_b      = 1'b1;
                state_nxt = NORM;
            end
            NORM: begin
                // Each operand stops on its own leading one or at the shift cap.
                shen_a = !msb_a && (cnt_a != CNT_MAX);
                shen_b = !msb_b && (cnt_b != CNT_MAX);
                if (shen_a) cnt_a_nxt = cnt_a + CNT_W'(1);
                if (shen_b) cnt_b_nxt = cnt_b + CNT_W'(1);
                if (!shen_a && !shen_b) begin
                    if ((cnt_a == CNT_MAX && !msb_a) || (cnt_b == CNT_MAX && !msb_b)) begin
                        zero_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = MUL;
                    end
                end
            end
            MUL: begin
                ld_res    = 1'b1;
                rem_nxt   = {1'b0, cnt_a} + {1'b0, cnt_b};
                state_nxt = (rem_nxt != '0) ? DENORM : DONE;
            end
            DENORM: begin
                shen_res = (rem != '0);
                if (shen_res) rem_nxt = rem - (CNT_W + 1)'(1);
                if (rem <= (CNT_W + 1)'(1)) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_norm_ctrl.sv
// Bench for shift_norm_ctrl: operand shift registers feed the MSBs back, a timeline
// model predicts every output each cycle, and directed cases pin the model.
module tb_shift_norm_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, start;
    logic             msb_a, msb_b;
    logic             ld_a, shen_a, ld_b, shen_b, ld_res, shen_res;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             busy, done, zero;

    logic [15:0] op_a = '0, op_b = '0;
    logic [15:0] reg_a = '0, reg_b = '0;

    int cyc_total = 0, cyc_fail = 0;
    int lit_total = 0, lit_fail = 0;

    shift_norm_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .msb_a(msb_a), .msb_b(msb_b),
        .ld_a(ld_a), .shen_a(shen_a), .ld_b(ld_b), .shen_b(shen_b),
        .ld_res(ld_res), .shen_res(shen_res), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .busy(busy), .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    // Operand registers A and B (ser_in tied 0).
    always @(posedge clk) begin
        if (ld_a) reg_a <= op_a;
        else if (shen_a) reg_a <= {reg_a[14:0], 1'b0};
        if (ld_b) reg_b <= op_b;
        else if (shen_b) reg_b <= {reg_b[14:0], 1'b0};
    end
    assign msb_a = reg_a[15];
    assign msb_b = reg_b[15];

    // Model: mt = cycle index since accept (0 = idle); h* = values held after an operation.
    int mt = 0, mka = 0, mkb = 0, hka = 0, hkb = 0;
    bit mz = 0, hz = 0, chk_en = 0;

    function automatic int lead_zeros(input logic [15:0] v);
        for (int i = 15; i >= 0; i--)
            if (v[i]) return 15 - i;
        return 15;
    endfunction

    function automatic int tdone();
        int n;
        n = ((mka > mkb) ? mka : mkb) + 1;
        return mz ? n + 2 : n + 3 + mka + mkb;
    endfunction

    function automatic logic [16:0] expect_vec(input int t);
        int  n, s, ca, cb;
        bit  norm, e_lda, e_sha, e_shb, e_ldr, e_shr, e_done, e_z;
        if (t == 0) return {8'b0, hz, 4'(hka), 4'(hkb)};
        n      = ((mka > mkb) ? mka : mkb) + 1;
        s      = mka + mkb;
        norm   = (t >= 2) && (t <= n + 1);
        e_lda  = (t == 1);
        e_sha  = norm && (t - 2 < mka);
        e_shb  = norm && (t - 2 < mkb);
        e_ldr  = !mz && (t == n + 2);
        e_shr  = !mz && (t >= n + 3) && (t <= n + 2 + s);
        e_done = (t == tdone());
        e_z    = e_done && mz;
        ca     = (t == 1) ? 0 : norm ? ((t - 2 < mka) ? t - 2 : mka) : mka;
        cb     = (t == 1) ? 0 : norm ? ((t - 2 < mkb) ? t - 2 : mkb) : mkb;
        return {e_lda, e_sha, e_lda, e_shb, e_ldr, e_shr, 1'b1, e_done, e_z, 4'(ca), 4'(cb)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mt     <= 0;
            hka    <= 0;
            hkb    <= 0;
            hz     <= 0;
            chk_en <= 1;
        end else if (mt == 0) begin
            if (start) begin
                mka <= lead_zeros(op_a);
                mkb <= lead_zeros(op_b);
                mz  <= (op_a == 16'h0) || (op_b == 16'h0);
                mt  <= 1;
            end
        end else if (mt == tdone()) begin
            hka <= mka;
            hkb <= mkb;
            hz  <= mz;
            mt  <= 0;
        end else begin
            mt <= mt + 1;
        end
    end

    always @(negedge clk) begin
        logic [16:0] act, exp_v;
        if (chk_en) begin
            exp_v = expect_vec(mt);
            act   = {ld_a, shen_a, ld_b, shen_b, ld_res, shen_res, busy, done, zero, cnt_a, cnt_b};
            cyc_total++;
            if (act !== exp_v) begin
                cyc_fail++;
                $display("FAIL cycle t=%0d outputs actual=%h required=%h", mt, act, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        lit_total++;
        if (act != exp_v) begin
            lit_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit hold_start,
                          output int lat, output int n_lda, output int n_sha, output int n_shb,
                          output int n_ldr, output int n_shr, output int shr_span);
        int first, last;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        lat = -1; n_lda = 0; n_sha = 0; n_shb = 0; n_ldr = 0; n_shr = 0;
        first = -1; last = -2;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (ld_a) n_lda++;
            if (shen_a) n_sha++;
            if (shen_b) n_shb++;
            if (ld_res) n_ldr++;
            if (shen_res) begin
                if (first < 0) first = c;
                last = c;
                n_shr++;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        shr_span = last - first + 1;
    endtask

    initial begin
        int lat, n_lda, n_sha, n_shb, n_ldr, n_shr, span, n_done;
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cnt_a", int'(cnt_a), 0);
        rst = 1'b0;

        // Both operands already normalized.
        run_op(16'h8000, 16'h8000, 0, lat, n_lda, n_sha, n_shb, n_ldr, n_shr, span);
        chk("t1_latency", lat, 4);
        chk("t1_shen_a", n_sha, 0);
        chk("t1_ld_res", n_ldr, 1);
        chk("t1_shen_res", n_shr, 0);
        @(negedge clk);
        chk("t1_cnt_a", int'(cnt_a), 0);
        chk("t1_zero", int'(zero), 0);

        run_op(16'h0001, 16'h0010, 0, lat, n_lda, n_sha, n_shb, n_ldr, n_shr, span);
        chk("t2_shen_a", n_sha, 15);
        chk("t2_shen_b", n_shb, 11);
        chk("t2_ld_res", n_ldr, 1);
        chk("t2_shen_res", n_shr, 26);
        chk("t2_shen_res_span", span, 26);
        chk("t2_latency", lat, 45);
        @(negedge clk);
        chk("t2_cnt_a", int'(cnt_a), 15);
        chk("t2_cnt_b", int'(cnt_b), 11);
        chk("t2_zero", int'(zero), 0);

        // Zero operand: no multiply, no de-normalization.
        run_op(16'h0000, 16'h1234, 0, lat, n_lda, n_sha, n_shb, n_ldr, n_shr, span);
        chk("t3_shen_a", n_sha, 15);
        chk("t3_shen_b", n_shb, 3);
        chk("t3_ld_res", n_ldr, 0);
        chk("t3_shen_res", n_shr, 0);
        chk("t3_latency", lat, 18);
        @(negedge clk);
        chk("t3_zero", int'(zero), 1);
        chk("t3_cnt_a", int'(cnt_a), 15);
        chk("t3_cnt_b", int'(cnt_b), 3);

        run_op(16'h4000, 16'h8000, 0, lat, n_lda, n_sha, n_shb, n_ldr, n_shr, span);
        chk("t4_latency", lat, 6);
        chk("t4_shen_res", n_shr, 1);
        @(negedge clk);
        chk("t4_cnt_a", int'(cnt_a), 1);
        chk("t4_cnt_b", int'(cnt_b), 0);

        // start held high across a whole operation.
        run_op(16'h0100, 16'h0001, 1, lat, n_lda, n_sha, n_shb, n_ldr, n_shr, span);
        chk("t5_single_load", n_lda, 1);
        chk("t5_latency", lat, 41);
        @(negedge clk);
        chk("t5_idle_gap_busy", int'(busy), 0);
        @(negedge clk);
        chk("t5_restart_ld_a", int'(ld_a), 1);
        start = 1'b0;
        n_done = 0;
        for (int c = 0; c < 100 && n_done == 0; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("t5_second_done", n_done, 1);

        // Reset during the 5th NORM cycle.
        @(negedge clk);
        op_a = 16'h0001; op_b = 16'h0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_norm_shen_a", int'(shen_a), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_strobes", int'({ld_a, shen_a, ld_b, shen_b, ld_res, shen_res}), 0);
        chk("t6_cnt_a", int'(cnt_a), 0);
        chk("t6_cnt_b", int'(cnt_b), 0);
        rst = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("t6_no_done_after_reset", n_done, 0);

        $display("%0d/%0d checks passed",
                 (cyc_total - cyc_fail) + (lit_total - lit_fail), cyc_total + lit_total);
        $finish;
    end

endmodule

// File: doc/shift_norm_ctrl.md
Name: shift_norm_ctrl

Overview:
FSM controller that sequences three `shift_reg` instances in the approximate-multiplier datapath: operand registers A and B, and the result register R. On `start` it does four things in order:
- Parallel-loads A and B.
- Shifts each one left independently until its MSB is 1 (leading-one normalization), counting the shifts.
- Triggers one result load.
- Issues a de-normalization shift burst to R of length ka+kb.

It reports completion with a one-cycle `done` pulse and flags a zero operand.

Parameters:
- WIDTH, 16, operand shift register width.
- CNT_W, $clog2(WIDTH), width of each per-operand shift counter; must hold WIDTH-1.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset: synchronous, active-high; returns FSM to IDLE.
- start  in  1  request a new operation; sampled only in IDLE.
- msb_a  in  1  MSB_out of operand register A.
- msb_b  in  1  MSB_out of operand register B.
- ld_a  out  1  parallel load of A.
- shen_a  out  1  left-shift enable of A (ser_in tied 0 externally).
- ld_b  out  1  parallel load of B.
- shen_b  out  1  left-shift enable of B.
- ld_res  out  1  parallel load of R from the multiplier output.
- shen_res  out  1  shift enable of R.
- cnt_a  out  CNT_W  shifts applied to A (ka).
- cnt_b  out  CNT_W  shifts applied to B (kb).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- zero  out  1  result-is-zero flag, valid from DONE until the next start is accepted.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high, and has priority over everything else.
- Reset values: state=IDLE; all outputs 0; cnt_a=cnt_b=0; remaining-shift counter rem=0; zero=0.
- States: IDLE, LOAD, NORM, MUL, DENORM, DONE.
- IDLE:
  - All strobes are 0.
  - start=1 moves to LOAD, clears cnt_a, cnt_b and zero.
  - start is ignored in every other state; there is no queuing.
- LOAD: ld_a=ld_b=1 for exactly one cycle, then go to NORM.
- NORM, per-operand shift enables:
  - shen_a = !msb_a && (cnt_a != WIDTH-1).
  - shen_b = !msb_b && (cnt_b != WIDTH-1).
  - Each cnt increments on the same edge as its shen.
  - A and B shift concurrently and stop independently.
- NORM, exit when both shen_a and shen_b are 0 in the same cycle:
  - If (cnt_a==WIDTH-1 && !msb_a) or (cnt_b==WIDTH-1 && !msb_b), an operand is zero: set zero=1 and go directly to DONE. ld_res and shen_res are never asserted.
  - Otherwise go to MUL.
- MUL: ld_res=1 for one cycle. On the same edge, load rem = cnt_a + cnt_b (CNT_W+1 bits, max 2*WIDTH-2). Next state is DENORM if the sum is nonzero, else DONE.
- DENORM: shen_res = (rem != 0); rem decrements per asserted cycle. Go to DONE on the cycle rem reaches 0, so shen_res is high for exactly ka+kb cycles.
- DONE: done=1 for one cycle, then IDLE. cnt_a, cnt_b and zero hold their values until the next accepted start.
- Invariants:
  - ld_x and shen_x are never high in the same cycle.
  - No strobe is asserted in IDLE or DONE.
  - ld_res and shen_res are mutually exclusive.
- Latency from the start-accept edge to the done pulse = 1 (LOAD) + N + 1 (MUL) + (ka+kb) + 1 (DONE) cycles, where N = max(ka,kb)+1 for the NORM stay. A zero operand omits MUL and DENORM.
- Reset mid-operation (any state) aborts immediately, with no further strobes after the reset edge.

Test Plan:
- WIDTH=16, start with A=0x8000, B=0x8000:
  - ld_a/ld_b 1 cycle, then NORM for 1 cycle with no shen.
  - ld_res 1 cycle, DENORM skipped.
  - done 4 cycles after accept; cnt_a=cnt_b=0, zero=0.
- A=0x0001, B=0x0010:
  - shen_a high 15 cycles, shen_b high 11 cycles; cnt_a=15, cnt_b=11.
  - Exactly one ld_res, then shen_res high for exactly 26 consecutive cycles.
  - done once, zero=0.
- A=0x0000, B=0x1234:
  - shen_a 15 cycles, cnt_a=15, shen_b 3 cycles.
  - zero=1; ld_res and shen_res never asserted; done pulses.
- Start held high continuously during an A=0x0100, B=0x0001 operation: no second LOAD until DONE→IDLE; the next operation begins on the first IDLE cycle.
- rst=1 during the 5th NORM cycle: on the next edge, state=IDLE, all strobes 0, cnt_a=cnt_b=0, busy=0, and no done pulse.
- A=0x4000, B=0x8000: ka=1, kb=0; shen_res exactly 1 cycle; done 6 cycles after accept.
